aes_vector_sequencer: RTL and testbench

- Synthesizable, parametrised stimulus-and-check engine for AES pipelines, generalising the HDL-side test transactor.
- Accepts test vectors over a valid/ready handshake and drives one DUT stimulus per cycle, either a directed vector or a walking-bit sweep with normal and inverted key.
- Tracks expected results in a latency-matched delay line and compares the DUT output in hardware.
- Reports saturating pass/fail counters and a done flag; sits between the input message pipe and an encoder, decoder or encoder→decoder chain.

---
 rtl/aes_vector_sequencer.sv | 154 +++++++++++++++
 tb/tb_aes_vector_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_vector_sequencer.sv
// Stimulus-and-check engine for AES pipelines: drives directed or walking-bit sweep
// stimuli and checks DUT output against a latency-matched expected-value delay line.
module aes_vector_sequencer #(
  parameter int DATA_W     = 128,
  parameter int KEY_W      = 256,
  parameter int CHECK_LAT  = 10,
  parameter int SWEEP_BITS = 128,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic              vec_type,
  input  logic              vec_last,
  input  logic [DATA_W-1:0] vec_plain,
  input  logic [KEY_W-1:0]  vec_key,
  input  logic [DATA_W-1:0] vec_expect,
  output logic              stim_valid,
  output logic [DATA_W-1:0] stim_data,
  output logic [KEY_W-1:0]  stim_key,
  input  logic              dut_valid,
  input  logic [DATA_W-1:0] dut_data,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  localparam int KW = $clog2(2*SWEEP_BITS+1);
  localparam logic [KW-1:0] K_INV = KW'(SWEEP_BITS);
  localparam logic [KW-1:0] K_END = KW'(2*SWEEP_BITS);

  state_t                    r_state;
  logic [KW-1:0]             r_k;
  logic                      r_sw_last;
  logic [DATA_W-1:0]         r_sw_plain;
  logic [KEY_W-1:0]          r_sw_key;
  logic                      r_stim_valid;
  logic [DATA_W-1:0]         r_stim_data;
  logic [KEY_W-1:0]          r_stim_key;
  logic [DATA_W-1:0]         r_exp;
  logic                      r_done;
  logic [CHECK_LAT-1:0]      r_vld_pipe;
  logic [CHECK_LAT-1:0][DATA_W-1:0] r_exp_pipe;
  logic [CNT_W-1:0]          r_pass;
  logic [CNT_W-1:0]          r_fail;

  logic [KW-1:0]     w_bit_idx;
  logic [DATA_W-1:0] w_flip;
  logic [DATA_W-1:0] w_sw_data;
  logic [KEY_W-1:0]  w_sw_key;
  logic              w_inflight;
  logic              w_due;
  logic              w_hit;
  logic              w_miss;

  // Step k walks bit (k mod SWEEP_BITS); the second half inverts the key; k==2*SWEEP_BITS restores.
  assign w_bit_idx = (r_k < K_INV) ? r_k : r_k - K_INV;
  assign w_flip    = (r_k == K_END) ? '0 : (DATA_W'(1) << w_bit_idx);
  assign w_sw_data = r_sw_plain ^ w_flip;
  assign w_sw_key  = (r_k >= K_INV && r_k != K_END) ? ~r_sw_key : r_sw_key;

  // Entries that will still be in the delay line after this edge's shift.
  assign w_inflight = r_stim_valid | (|(r_vld_pipe << 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_sw_last    <= 1'b0;
      r_sw_plain   <= '0;
      r_sw_key     <= '0;
      r_stim_valid <= 1'b0;
      r_stim_data  <= '0;
      r_stim_key   <= '0;
      r_exp        <= '0;
      r_done       <= 1'b0;
    end else begin
      r_stim_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (vec_valid) begin
          if (vec_type) begin
            r_sw_plain <= vec_plain;
            r_sw_key   <= vec_key;
            r_sw_last  <= vec_last;
            r_k        <= '0;
            r_state    <= S_SWEEP;
          end else begin
            r_stim_valid <= 1'b1;
            r_stim_data  <= vec_plain;
            r_stim_key   <= vec_key;
            r_exp        <= vec_expect;
            if (vec_last) r_state <= S_DRAIN;
          end
        end
        S_SWEEP: begin
          r_stim_valid <= 1'b1;
          r_stim_data  <= w_sw_data;
          r_stim_key   <= w_sw_key;
          r_exp        <= w_sw_data;
          r_k          <= r_k + KW'(1);
          if (r_k == K_END) r_state <= r_sw_last ? S_DRAIN : S_IDLE;
        end
        S_DRAIN: if (!w_inflight) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_exp_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= r_stim_valid;
      r_exp_pipe[0] <= r_exp;
      for (int i = 1; i < CHECK_LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_exp_pipe[i] <= r_exp_pipe[i-1];
      end
    end
  end

  // A due check either hits or misses; a DUT beat with nothing due is spurious.
  assign w_due  = r_vld_pipe[CHECK_LAT-1];
  assign w_hit  = w_due & dut_valid & (dut_data == r_exp_pipe[CHECK_LAT-1]);
  assign w_miss = (w_due & ~w_hit) | (~w_due & dut_valid);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pass <= '0;
      r_fail <= '0;
    end else begin
      if (w_hit  && r_pass != '1) r_pass <= r_pass + CNT_W'(1);
      if (w_miss && r_fail != '1) r_fail <= r_fail + CNT_W'(1);
    end
  end

  assign vec_ready  = (r_state == S_IDLE);
  assign stim_valid = r_stim_valid;
  assign stim_data  = r_stim_data;
  assign stim_key   = r_stim_key;
  assign pass_count = r_pass;
  assign fail_count = r_fail;
  assign busy       = (r_state != S_IDLE) | r_stim_valid | (|r_vld_pipe);
  assign done       = r_done;

endmodule

// File: tb/tb_aes_vector_sequencer.sv
// Directed bench: loopback/xor DUT model with fault injection, table of single-vector
// runs plus hand sequences for back-to-back, sweep, missing/spurious, saturation, reset.
module tb_aes_vector_sequencer;
  localparam int DW = 32, KWD = 64, L = 3, SB = 4, CW = 4;
  localparam logic [31:0] XK = 32'hA5A5A5A4;

  logic clock, reset;
  logic vec_valid, vec_ready, vec_type, vec_last;
  logic [DW-1:0] vec_plain, vec_expect, stim_data, dut_data;
  logic [KWD-1:0] vec_key, stim_key;
  logic stim_valid, dut_valid, busy, done;
  logic [CW-1:0] pass_count, fail_count;
  logic s_ready, s_stim_valid, s_busy, s_done;
  logic [DW-1:0] s_stim_data;
  logic [KWD-1:0] s_stim_key;
  logic [1:0] s_pass, s_fail;

  aes_vector_sequencer #(.DATA_W(DW), .KEY_W(KWD), .CHECK_LAT(L), .SWEEP_BITS(SB), .CNT_W(CW)) u_dut (
    .clock(clock), .reset(reset), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_type(vec_type), .vec_last(vec_last), .vec_plain(vec_plain), .vec_key(vec_key),
    .vec_expect(vec_expect), .stim_valid(stim_valid), .stim_data(stim_data), .stim_key(stim_key),
    .dut_valid(dut_valid), .dut_data(dut_data), .pass_count(pass_count), .fail_count(fail_count),
    .busy(busy), .done(done));

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  aes_vector_sequencer #(.DATA_W(DW), .KEY_W(KWD), .CHECK_LAT(L), .SWEEP_BITS(SB), .CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .vec_valid(vec_valid), .vec_ready(s_ready),
    .vec_type(vec_type), .vec_last(vec_last), .vec_plain(vec_plain), .vec_key(vec_key),
    .vec_expect(vec_expect), .stim_valid(s_stim_valid), .stim_data(s_stim_data), .stim_key(s_stim_key),
    .dut_valid(dut_valid), .dut_data(dut_data), .pass_count(s_pass), .fail_count(s_fail),
    .busy(s_busy), .done(s_done));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // DUT model: L-cycle pipe returning stim_data (loopback) or stim_data^XK.
  logic loopback, spur;
  int drop_n, corrupt_n, resp_n;
  logic [L-1:0] p_v;
  logic [DW-1:0] p_d [L];

  always @(posedge clock) begin
    if (reset) begin
      p_v <= '0;
      resp_n <= 0;
      for (int i = 0; i < L; i++) p_d[i] <= '0;
    end else begin
      p_v <= {p_v[L-2:0], stim_valid};
      p_d[0] <= loopback ? stim_data : (stim_data ^ XK);
      for (int i = 1; i < L; i++) p_d[i] <= p_d[i-1];
      if (p_v[L-1]) resp_n <= resp_n + 1;
    end
  end

  assign dut_valid = (p_v[L-1] && resp_n != drop_n) || spur;
  assign dut_data  = p_d[L-1] ^ ((resp_n == corrupt_n) ? 32'd1 : 32'd0);

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; vec_valid = 1'b0; vec_type = 1'b0; vec_last = 1'b0;
    spur = 1'b0; drop_n = -1; corrupt_n = -1; loopback = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic offer(input logic t, input logic lst, input logic [31:0] p, input logic [63:0] k,
                       input logic [31:0] g);
    vec_valid = 1'b1; vec_type = t; vec_last = lst; vec_plain = p; vec_key = k; vec_expect = g;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!done) chk("done_timeout", 64'(done), 64'd1);
  endtask

  typedef struct {
    logic [31:0] plain;
    logic [63:0] key;
    logic [31:0] gold;
    int pass_e;
    int fail_e;
  } dvec_t;

  dvec_t tbl[5];
  logic [31:0] sw_d [9];
  logic sw_inv [9];

  initial begin
    int n, low;
    logic [63:0] skey;
    tbl[0] = '{32'h00000001, 64'h0123456789ABCDEF, 32'hA5A5A5A5, 1, 0};
    tbl[1] = '{32'h00000000, 64'hFFFF0000FFFF0000, 32'hA5A5A5A4, 1, 0};
    tbl[2] = '{32'hFFFFFFFF, 64'h0000000000000001, 32'h5A5A5A5B, 1, 0};
    tbl[3] = '{32'h12345678, 64'hDEADBEEFCAFEF00D, 32'hB791F3DC, 1, 0};
    tbl[4] = '{32'h12345678, 64'hDEADBEEFCAFEF00D, 32'hB791F3DD, 0, 1};
    sw_d = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h1, 32'h2, 32'h4, 32'h8, 32'h0};
    sw_inv = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

    reset = 1'b1; vec_valid = 1'b0; vec_type = 1'b0; vec_last = 1'b0;
    vec_plain = '0; vec_key = '0; vec_expect = '0;
    spur = 1'b0; drop_n = -1; corrupt_n = -1; loopback = 1'b0;
    do_reset();

    chk("rst_ready", 64'(vec_ready), 64'd1);
    chk("rst_stim_valid", 64'(stim_valid), 64'd0);
    chk("rst_stim_data", 64'(stim_data), 64'd0);
    chk("rst_counts", {pass_count, fail_count}, '0);
    chk("rst_busy_done", {busy, done}, '0);

    // Single directed runs, each ending in DONE.
    for (int t = 0; t < 5; t++) begin
      do_reset();
      offer(1'b0, 1'b1, tbl[t].plain, tbl[t].key, tbl[t].gold);
      @(negedge clock);
      vec_valid = 1'b0;
      chk($sformatf("t%0d_stim", t), {stim_valid, stim_data}, {1'b1, tbl[t].plain});
      chk($sformatf("t%0d_key", t), stim_key, tbl[t].key);
      wait_done(n);
      chk($sformatf("t%0d_done_lat", t), 64'(n), 64'd4);
      chk($sformatf("t%0d_pass", t), 64'(pass_count), 64'(tbl[t].pass_e));
      chk($sformatf("t%0d_fail", t), 64'(fail_count), 64'(tbl[t].fail_e));
      chk($sformatf("t%0d_ready_done", t), 64'(vec_ready), 64'd0);
    end

    // Back-to-back directed, 3rd response corrupted.
    do_reset();
    corrupt_n = 2;
    for (int i = 0; i < 5; i++) begin
      offer(1'b0, i == 4, 32'h10 + i, 64'h1111 * (i + 1), (32'h10 + i) ^ XK);
      chk($sformatf("b2b_ready%0d", i), 64'(vec_ready), 64'd1);
      @(negedge clock);
      chk($sformatf("b2b_stim%0d", i), {stim_valid, stim_data}, {1'b1, 32'h10 + i});
    end
    vec_valid = 1'b0;
    wait_done(n);
    chk("b2b_pass", 64'(pass_count), 64'd4);
    chk("b2b_fail", 64'(fail_count), 64'd1);

    // Walking-bit sweep through a loopback DUT.
    do_reset();
    loopback = 1'b1;
    skey = 64'h0F0F0F0F0F0F0F0F;
    offer(1'b1, 1'b0, 32'h0, skey, 32'h0);
    @(negedge clock);
    vec_valid = 1'b0;
    low = 0;
    for (int j = 0; j <= 10; j++) begin
      if (!vec_ready) low++;
      if (j >= 1 && j <= 9) begin
        chk($sformatf("sw_d%0d", j - 1), {stim_valid, stim_data}, {1'b1, sw_d[j-1]});
        chk($sformatf("sw_k%0d", j - 1), stim_key, sw_inv[j-1] ? ~skey : skey);
      end else if (j == 0 || j == 10) begin
        chk($sformatf("sw_gap%0d", j), 64'(stim_valid), 64'd0);
      end
      @(negedge clock);
    end
    chk("sw_ready_low", 64'(low), 64'd9);
    repeat (4) @(negedge clock);
    chk("sw_pass", 64'(pass_count), 64'd9);
    chk("sw_fail", 64'(fail_count), 64'd0);
    chk("sw_idle_busy", {vec_ready, busy}, 64'b10);

    // Missing response plus one spurious beat in an idle gap.
    do_reset();
    drop_n = 1;
    for (int i = 0; i < 3; i++) begin
      offer(1'b0, 1'b0, 32'h100 + i, 64'h0, (32'h100 + i) ^ XK);
      @(negedge clock);
    end
    vec_valid = 1'b0;
    repeat (8) @(negedge clock);
    spur = 1'b1;
    @(negedge clock);
    spur = 1'b0;
    repeat (2) @(negedge clock);
    chk("ms_pass", 64'(pass_count), 64'd2);
    chk("ms_fail", 64'(fail_count), 64'd2);

    // Six failing checks: 4-bit counter reads 6, 2-bit counter saturates at 3.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      offer(1'b0, i == 5, 32'd1 + i, 64'h0, 32'h0);
      @(negedge clock);
    end
    vec_valid = 1'b0;
    wait_done(n);
    chk("sat_fail_w4", 64'(fail_count), 64'd6);
    chk("sat_fail_w2", 64'(s_fail), 64'd3);
    chk("sat_pass", 64'(pass_count), 64'd0);

    // Reset mid-sweep, then a fresh directed vector.
    do_reset();
    loopback = 1'b1;
    offer(1'b1, 1'b1, 32'h0, 64'hAAAA, 32'h0);
    @(negedge clock);
    vec_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("mr_k2", {stim_valid, stim_data}, {1'b1, 32'h4});
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mr_ready", 64'(vec_ready), 64'd1);
    chk("mr_stim", {stim_valid, stim_data, stim_key}, '0);
    chk("mr_status", {pass_count, fail_count, busy, done}, '0);
    loopback = 1'b0;
    offer(1'b0, 1'b1, 32'h77, 64'h5, 32'h77 ^ XK);
    @(negedge clock);
    vec_valid = 1'b0;
    wait_done(n);
    chk("mr_after", {pass_count, fail_count, done}, {4'd1, 4'd0, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
